usb_stream_ctrl: RTL and testbench
==================================

# usb_stream_ctrl

Command controller between the FT245 simple interface and the sample FIFO / AM modulator. It parses a byte-oriented command stream from the host and routes sample bursts into the FIFO with back-pressure. It gates the modulator enable with a prefill threshold and returns a status byte on request. It sits in the top level between `ft245_block` and the `fifo`/`modulator` pair.

## Interface
- `FIFO_DEPTH`, 1024: sample FIFO depth in bytes; sets the internal level counter width to clog2(FIFO_DEPTH+1).
- `PREFILL`, 512: FIFO level required before `mod_enable` rises after START; range 1..FIFO_DEPTH.
- `clk`  in  1  system clock (128 MHz PLL output).
- `rst`  in  1  asynchronous, active-low reset.
- `rx_data_si`  in  8  byte from the host.
- `rx_rdy_si`  in  1  `rx_data_si` is valid.
- `rx_ack_si`  out  1  one-cycle pulse that consumes the current rx byte.
- `tx_data_si`  out  8  status byte to the host.
- `tx_rdy_si`  out  1  `tx_data_si` is valid; held until acknowledged.
- `tx_ack_si`  in  1  wrapper accepted the tx byte.
- `fifo_wr_data`  out  8  sample to the FIFO.
- `fifo_wr_en`  out  1  one-cycle write strobe.
- `fifo_full`, `fifo_empty`  in  1 each  FIFO flags.
- `mod_read`  in  1  modulator pop strobe.
- `mod_enable`  out  1  modulator enable.
- `status`  out  8  live status byte, for the LEDs.

## Operation
- Opcodes: START 0xA1, STOP 0xA2, SAMPLES 0xA3, STATUS 0xA4.
- States: IDLE, LEN, DATA, TX.
- IDLE, byte accepted:
  - START: set `run_req`.
  - STOP: clear `run_req` and drop `mod_enable`.
  - SAMPLES: go to LEN.
  - STATUS: latch `status` into `tx_data_si` and go to TX.
  - Any other byte: set sticky `proto_err` and stay in IDLE.
- LEN: accepted byte N loads the burst counter; N=0 means 256. Go to DATA.
- DATA:
  - Accept a byte only when `fifo_full`=0.
  - Each accepted byte: `fifo_wr_data`=byte, `fifo_wr_en` pulses, burst counter decrements.
  - Counter reaches 0: return to IDLE.
  - While `fifo_full`=1, no ack is issued (back-pressure to the host).
- TX: hold `tx_rdy_si`=1 until `tx_ack_si`=1, then return to IDLE. `proto_err` and `underrun` are cleared in the ack cycle; a new event in that same cycle wins and re-sets the flag.
- Level counter:
  - +1 on `fifo_wr_en`; −1 on `mod_read` with `fifo_empty`=0.
  - Both in the same cycle: no change.
  - Saturates at 0 and FIFO_DEPTH.
- Enable rule:
  - `mod_enable` rises when `run_req`=1 and level ≥ PREFILL.
  - It then stays high while `run_req`=1, regardless of level.
  - It falls on STOP.
- `status` bits:
  - [0] `mod_enable`, [1] `fifo_empty`, [2] `fifo_full`, [3] `underrun`, [4] `proto_err`, [7:5] = 3'b101.

## Timing
- Reset values: `rx_ack_si`=0, `tx_rdy_si`=0, `tx_data_si`=0, `fifo_wr_en`=0, `fifo_wr_data`=0, `mod_enable`=0, `status`=8'hA2 (signature plus `fifo_empty`, assuming the FIFO is empty out of reset). State IDLE; counters, `run_req` and sticky flags all 0.
- Rx handshake:
  - `rx_ack_si` is registered and asserts the cycle after `rx_rdy_si`=1 is sampled with the byte acceptable.
  - The cycle after an ack pulse is a holdoff: `rx_rdy_si` is ignored.
  - Peak rate is one byte per 2 clk.
- `fifo_wr_en` pulses in the same cycle as the `rx_ack_si` for that byte; data is registered.
- `mod_enable` rises 1 clk after level reaches PREFILL, and falls 1 clk after STOP is accepted.
- STATUS command: `tx_rdy_si` rises 1 clk after the STATUS ack. The latched byte reflects state in the ack cycle.
- Reset mid-burst: the state machine returns to IDLE, the remaining burst count is discarded, and `mod_enable` drops immediately (asynchronously).

## Configuration
- `USB_STREAM_CTRL_UNDERRUN_EN` defined:
  - `underrun` sets when `mod_enable`=1 and `fifo_empty`=1 in the same cycle.
  - It is sticky until a STATUS byte is acknowledged.
  - On underrun, `mod_enable` falls; `run_req` stays set, so the enable rule re-applies and the prefill refill is automatic.
- Macro not defined: `status[3]` is tied to 0, and `mod_enable` ignores `fifo_empty` once enabled.

## Structure
- Package `usb_stream_pkg`: the opcode localparams, the state enum, the status bit indices and the 3'b101 signature.
- Sub-module `fifo_level_tracker`: the level counter, the PREFILL compare and the saturation logic.

## Test plan
- Send A3, 04, 11 22 33 44 → four `fifo_wr_en` pulses carrying 11, 22, 33, 44; state returns to IDLE.
- PREFILL=4: send A1, then A3 03 + 3 bytes → `mod_enable`=0. Send A3 01 + 1 byte → `mod_enable`=1 one clk after the 4th write.
- Hold `fifo_full`=1 during a 2-byte burst → no `rx_ack_si` while full. Release → both bytes are written.
- Send 0x55, then A4 → `tx_data_si`=8'b101_1_0xx1-style with bit4=1. Send a second A4 after the ack → bit4=0.
- UNDERRUN_EN: running with `fifo_empty` forced to 1 → `status[3]`=1 and `mod_enable` drops. Refill to PREFILL → `mod_enable` re-asserts.
- Assert `rst`=0 mid-burst (after 2 of 5 bytes) → all outputs return to reset values. A following A4 reports 8'hA2.

Source files
------------

// File: rtl/usb_stream_pkg.sv
// usb_stream_pkg: opcodes, FSM states and status byte layout shared by usb_stream_ctrl.
package usb_stream_pkg;
    localparam logic [7:0] OP_START   = 8'hA1;
    localparam logic [7:0] OP_STOP    = 8'hA2;
    localparam logic [7:0] OP_SAMPLES = 8'hA3;
    localparam logic [7:0] OP_STATUS  = 8'hA4;
    localparam logic [2:0] STATUS_SIG = 3'b101;
    localparam int ST_EN    = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_URUN  = 3;
    localparam int ST_PERR  = 4;
    typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_TX} state_t;
    function automatic logic is_opcode(input logic [7:0] b);
        return b == OP_START || b == OP_STOP || b == OP_SAMPLES || b == OP_STATUS;
    endfunction
endpackage

// File: rtl/fifo_level_tracker.sv
// fifo_level_tracker: saturating FIFO occupancy count and the prefill threshold compare.
module fifo_level_tracker #(
    parameter int FIFO_DEPTH = 1024,
    parameter int PREFILL    = 512
) (
    input  logic clk,
    input  logic rst,
    input  logic wr,
    input  logic rd,
    output logic prefill_ok
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    logic [LW-1:0] level;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) level <= '0;
        else if (wr && !rd && level != LW'(FIFO_DEPTH)) level <= level + LW'(1);
        else if (rd && !wr && level != '0) level <= level - LW'(1);
    end
    assign prefill_ok = level >= LW'(PREFILL);
endmodule

// File: rtl/usb_stream_ctrl.sv
// usb_stream_ctrl: FT245 command parser feeding the sample FIFO and gating the AM modulator.
// Define USB_STREAM_CTRL_UNDERRUN_EN to flag underrun and drop mod_enable when the FIFO runs dry.
module usb_stream_ctrl
    import usb_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 1024,
    parameter int PREFILL    = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data_si,
    input  logic       rx_rdy_si,
    output logic       rx_ack_si,
    output logic [7:0] tx_data_si,
    output logic       tx_rdy_si,
    input  logic       tx_ack_si,
    output logic [7:0] fifo_wr_data,
    output logic       fifo_wr_en,
    input  logic       fifo_full,
    input  logic       fifo_empty,
    input  logic       mod_read,
    output logic       mod_enable,
    output logic [7:0] status
);
    state_t state, state_nxt;
    logic take, tx_done, perr_evt, urun_evt, prefill_ok, run_req, proto_err, underrun;
    logic [8:0] burst;
    assign tx_done  = tx_rdy_si && tx_ack_si;
    assign perr_evt = take && state == S_IDLE && !is_opcode(rx_data_si);
`ifdef USB_STREAM_CTRL_UNDERRUN_EN
    assign urun_evt = mod_enable && fifo_empty;
`else
    assign urun_evt = 1'b0;
`endif
    fifo_level_tracker #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .PREFILL   (PREFILL)
    ) u_level (
        .clk       (clk),
        .rst       (rst),
        .wr        (fifo_wr_en),
        .rd        (mod_read && !fifo_empty),
        .prefill_ok(prefill_ok)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else state <= state_nxt;
    end
    // The ack register doubles as the one-cycle holdoff after each accepted byte.
    always_comb begin
        state_nxt = state;
        take = 1'b0;
        case (state)
            S_IDLE: begin
                take = rx_rdy_si && !rx_ack_si;
                if (take && rx_data_si == OP_SAMPLES) state_nxt = S_LEN;
                else if (take && rx_data_si == OP_STATUS) state_nxt = S_TX;
            end
            S_LEN: begin
                take = rx_rdy_si && !rx_ack_si;
                if (take) state_nxt = S_DATA;
            end
            S_DATA: begin
                take = rx_rdy_si && !rx_ack_si && !fifo_full;
                if (take && burst == 9'd1) state_nxt = S_IDLE;
            end
            S_TX: if (tx_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ack_si    <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            burst        <= '0;
            run_req      <= 1'b0;
            proto_err    <= 1'b0;
            underrun     <= 1'b0;
            mod_enable   <= 1'b0;
            tx_rdy_si    <= 1'b0;
            tx_data_si   <= '0;
        end else begin
            rx_ack_si  <= take;
            fifo_wr_en <= take && state == S_DATA;
            if (take && state == S_DATA) fifo_wr_data <= rx_data_si;
            if (take && state == S_LEN) burst <= {rx_data_si == 8'd0, rx_data_si};
            else if (take && state == S_DATA) burst <= burst - 9'd1;
            if (take && state == S_IDLE && rx_data_si == OP_START) run_req <= 1'b1;
            else if (take && state == S_IDLE && rx_data_si == OP_STOP) run_req <= 1'b0;
            proto_err  <= perr_evt || (proto_err && !tx_done);
            underrun   <= urun_evt || (underrun && !tx_done);
            mod_enable <= run_req && (mod_enable || prefill_ok) && !urun_evt;
            // Status is captured in the ack cycle of the STATUS byte, the first cycle spent in TX.
            if (state == S_TX && !tx_rdy_si) begin
                tx_rdy_si  <= 1'b1;
                tx_data_si <= status;
            end else if (tx_done) tx_rdy_si <= 1'b0;
        end
    end
    always_comb begin
        status = {STATUS_SIG, 5'b0};
        status[ST_EN]    = mod_enable;
        status[ST_EMPTY] = fifo_empty;
        status[ST_FULL]  = fifo_full;
        status[ST_URUN]  = underrun;
        status[ST_PERR]  = proto_err;
    end
endmodule

// File: tb/tb_usb_stream_ctrl.sv
// tb_usb_stream_ctrl: scoreboard bench with randomized command traffic and a high-level model.
module tb_usb_stream_ctrl;
    import usb_stream_pkg::*;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;
    logic clk = 1'b0, rst = 1'b0;
    logic [7:0] rx_data_si = '0, tx_data_si, fifo_wr_data, status;
    logic rx_rdy_si = 1'b0, rx_ack_si, tx_rdy_si, tx_ack_si = 1'b0, fifo_wr_en;
    logic fifo_full = 1'b0, fifo_empty = 1'b1, mod_read = 1'b0, mod_enable;
    int passed = 0, total = 0;
    logic [7:0] wr_q[$], tx_q[$];
    int lvl = 0;
    bit run = 0, en = 0, perr = 0, stall_en = 0, low_seen = 0;

    usb_stream_ctrl #(.FIFO_DEPTH(DEPTH), .PREFILL(PRE)) dut (
        .clk(clk), .rst(rst), .rx_data_si(rx_data_si), .rx_rdy_si(rx_rdy_si), .rx_ack_si(rx_ack_si),
        .tx_data_si(tx_data_si), .tx_rdy_si(tx_rdy_si), .tx_ack_si(tx_ack_si),
        .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .mod_read(mod_read), .mod_enable(mod_enable), .status(status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: pops the scoreboard on every FIFO write and tx byte, and acknowledges tx.
    always @(negedge clk) begin
        if (fifo_wr_en) begin
            if (wr_q.size() == 0) check("write_queue", wr_q.size(), 1);
            else check("fifo_wr_data", fifo_wr_data, wr_q.pop_front());
        end
        if (tx_ack_si) tx_ack_si = 1'b0;
        else if (tx_rdy_si) begin
            if (tx_q.size() == 0) check("tx_queue", tx_q.size(), 1);
            else check("tx_data", tx_data_si, tx_q.pop_front());
            tx_ack_si = 1'b1;
        end
    end

    always @(posedge clk) if (stall_en) begin
        #1 fifo_full = ($urandom_range(0, 3) == 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic stop_stall;
        stall_en = 0;
        @(posedge clk);
        #2 fifo_full = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_data_si = b;
        rx_rdy_si = 1'b1;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!rx_ack_si && n < 300);
        check("rx_ack", rx_ack_si, 1);
        rx_rdy_si = 1'b0;
    endtask

    task automatic settle(input string name);
        repeat (4) @(posedge clk);
        #1 check(name, mod_enable, en);
    endtask

    task automatic burst(input int n, input bit stall);
        logic [7:0] b;
        send(OP_SAMPLES);
        send(8'(n));
        stall_en = stall;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            wr_q.push_back(b);
            send(b);
        end
        if (stall) stop_stall();
        lvl = (lvl + n > DEPTH) ? DEPTH : lvl + n;
        if (run && lvl >= PRE) en = 1;
        settle("burst_en");
    endtask

    task automatic start_cmd;
        send(OP_START);
        run = 1;
        if (lvl >= PRE) en = 1;
        settle("start_en");
    endtask

    task automatic stop_cmd;
        send(OP_STOP);
        run = 0;
        en = 0;
        settle("stop_en");
    endtask

    task automatic bad_cmd;
        logic [7:0] b;
        b = 8'($urandom);
        while (is_opcode(b)) b = 8'($urandom);
        send(b);
        perr = 1;
        settle("bad_en");
    endtask

    task automatic status_cmd;
        tx_q.push_back({3'b101, perr, 1'b0, fifo_full, fifo_empty, en});
        send(OP_STATUS);
        perr = 0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_rx_ack"}, rx_ack_si, 0);
        check({tag, "_tx_rdy"}, tx_rdy_si, 0);
        check({tag, "_tx_data"}, tx_data_si, 0);
        check({tag, "_wr_en"}, fifo_wr_en, 0);
        check({tag, "_wr_data"}, fifo_wr_data, 0);
        check({tag, "_mod_enable"}, mod_enable, 0);
        check({tag, "_status"}, status, {3'b101, 2'b00, fifo_full, fifo_empty, 1'b0});
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        lvl = 0;
        run = 0;
        en = 0;
        perr = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] basic [4];
        logic [7:0] b0, b1;
        int acks;
        basic = '{8'h11, 8'h22, 8'h33, 8'h44};
        @(posedge clk);
        #1 reset_pulse("por");
        fifo_empty = 1'b0;
        send(OP_SAMPLES);
        send(8'd4);
        foreach (basic[i]) begin
            wr_q.push_back(basic[i]);
            send(basic[i]);
        end
        lvl = 4;
        settle("basic_en");
        reset_pulse("rst2");
        start_cmd();
        burst(3, 0);
        send(OP_SAMPLES);
        send(8'd1);
        b0 = 8'($urandom);
        wr_q.push_back(b0);
        send(b0);
        check("en_at_write", mod_enable, 0);
        repeat (2) @(posedge clk);
        #1 check("en_prefill", mod_enable, 1);
        lvl = 4;
        en = 1;
        stop_cmd();
        send(8'h55);
        perr = 1;
        settle("perr_en");
        status_cmd();
        status_cmd();
        send(OP_SAMPLES);
        send(8'd2);
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        wr_q.push_back(b0);
        wr_q.push_back(b1);
        fifo_full = 1'b1;
        rx_data_si = b0;
        rx_rdy_si = 1'b1;
        acks = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (rx_ack_si) acks++;
        end
        check("ack_while_full", acks, 0);
        fifo_full = 1'b0;
        send(b0);
        send(b1);
        lvl = (lvl + 2 > DEPTH) ? DEPTH : lvl + 2;
        settle("bp_en");
        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 5))
                0, 1: burst($urandom_range(1, 6), 1);
                2: start_cmd();
                3: stop_cmd();
                4: status_cmd();
                default: bad_cmd();
            endcase
        end
        status_cmd();
        burst(256, 1);
        stop_cmd();
        mod_read = 1'b1;
        repeat (DEPTH - PRE + 1) @(posedge clk);
        #1 mod_read = 1'b0;
        lvl = (lvl > DEPTH - PRE + 1) ? lvl - (DEPTH - PRE + 1) : 0;
        start_cmd();
        burst(1, 0);
        send(OP_SAMPLES);
        send(8'd5);
        for (int i = 0; i < 2; i++) begin
            b0 = 8'($urandom);
            wr_q.push_back(b0);
            send(b0);
        end
        @(negedge clk);
        #1 reset_pulse("mid");
        fifo_empty = 1'b1;
        status_cmd();
        fifo_empty = 1'b0;
        start_cmd();
        burst(4, 0);
        fifo_empty = 1'b1;
        low_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1 if (!mod_enable) low_seen = 1;
        end
`ifdef USB_STREAM_CTRL_UNDERRUN_EN
        check("underrun_flag", status[3], 1);
        check("underrun_drop", low_seen, 1);
`else
        check("underrun_flag", status[3], 0);
        check("underrun_drop", low_seen, 0);
`endif
        fifo_empty = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("wr_q_left", wr_q.size(), 0);
        check("tx_q_left", tx_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
